dkong_dma_mc: RTL and testbench

Parametrised multi-channel sprite/block DMA controller. It is the successor to the single-channel sprite DMA. Each channel has its own source base, destination base, length and mode (copy or fill). The controller uses the Z80 bus-request handshake, issues strobes on the 3.072 MHz CPU clock enable, and drives dual-port RAM source/destination ports in the top level.

---
 rtl/dkong_dma_mc.sv | 173 +++++++++++++++++
 tb/tb_dkong_dma_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_dma_mc.sv
// Multi-channel sprite/block DMA controller using the Z80 bus-request handshake.
// Steps advance on the CPU clock enable; copy reads run one tick ahead of writes.
module dkong_dma_mc #(
  parameter int CH = 2,
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET_n,
  input  logic                 I_CLK_EN,
  input  logic [CH-1:0]        I_DMA_TRIG,
  input  logic [CH*AW-1:0]     I_SRC_BASE,
  input  logic [CH*AW-1:0]     I_DST_BASE,
  input  logic [CH*(AW+1)-1:0] I_LEN,
  input  logic [CH-1:0]        I_MODE,
  input  logic [DW-1:0]        I_FILL,
  input  logic                 I_HLDA,
  input  logic [DW-1:0]        I_DMA_DS,
  output logic                 O_HRQ,
  output logic [AW-1:0]        O_DMA_AS,
  output logic                 O_DMA_CES,
  output logic [AW-1:0]        O_DMA_AD,
  output logic [DW-1:0]        O_DMA_DD,
  output logic                 O_DMA_CED,
  output logic                 O_BUSY,
  output logic [CH-1:0]        O_DONE
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_HOLD = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t        state_r;
  logic [CH-1:0] trig_prev_r, pend_r, ch_r;
  logic [CH-1:0] edge_s, clr_s, sel_oh_s;
  logic          sel_any_s, start_s, sel_mode_s;
  logic [CW-1:0] sel_idx_s;
  logic [AW-1:0] sel_src_s, sel_dst_s, src_r, dst_r;
  logic [AW:0]   sel_len_s, len_r, k_r;
  logic          mode_r, live_r, skip_wr_r;
  logic [DW-1:0] fill_r;

  // Lowest-index pending channel wins; fetch its configuration
  always_comb begin
    sel_any_s = |pend_r;
    sel_oh_s  = pend_r & (~pend_r + CH'(1));
    sel_idx_s = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      sel_idx_s = pend_r[i] ? CW'(i) : sel_idx_s;
    end
    sel_src_s  = I_SRC_BASE[int'(sel_idx_s) * AW +: AW];
    sel_dst_s  = I_DST_BASE[int'(sel_idx_s) * AW +: AW];
    sel_len_s  = I_LEN[int'(sel_idx_s) * (AW + 1) +: (AW + 1)];
    sel_mode_s = I_MODE[sel_idx_s];
  end

  assign edge_s  = I_DMA_TRIG & ~trig_prev_r;
  assign start_s = (state_r == ST_IDLE) && I_CLK_EN && sel_any_s;
  assign clr_s   = start_s ? sel_oh_s : '0;

  // Trigger edge detection and one-deep pending latch per channel
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      trig_prev_r <= '0;
      pend_r      <= '0;
    end else begin
      trig_prev_r <= I_DMA_TRIG;
      pend_r      <= (pend_r | edge_s) & ~clr_s;
    end
  end

  // Transfer sequencer with registered strobes, addresses and handshake outputs
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_r   <= ST_IDLE;
      ch_r      <= '0;
      src_r     <= '0;
      dst_r     <= '0;
      len_r     <= '0;
      mode_r    <= 1'b0;
      fill_r    <= '0;
      k_r       <= '0;
      live_r    <= 1'b0;
      skip_wr_r <= 1'b0;
      O_HRQ     <= 1'b0;
      O_BUSY    <= 1'b0;
      O_DMA_AS  <= '0;
      O_DMA_CES <= 1'b0;
      O_DMA_AD  <= '0;
      O_DMA_DD  <= '0;
      O_DMA_CED <= 1'b0;
      O_DONE    <= '0;
    end else begin
      O_DMA_CES <= 1'b0;
      O_DMA_CED <= 1'b0;
      O_DONE    <= '0;
      if (I_CLK_EN) begin
        case (state_r)
          ST_IDLE: begin
            if (sel_any_s) begin
              ch_r      <= sel_oh_s;
              src_r     <= sel_src_s;
              dst_r     <= sel_dst_s;
              len_r     <= sel_len_s;
              mode_r    <= sel_mode_s;
              fill_r    <= I_FILL;
              k_r       <= '0;
              live_r    <= 1'b0;
              skip_wr_r <= 1'b0;
              if (sel_len_s == '0) begin
                O_DONE <= sel_oh_s;
              end else begin
                state_r <= ST_REQ;
                O_HRQ   <= 1'b1;
                O_BUSY  <= 1'b1;
              end
            end
          end
          ST_REQ: begin
            if (I_HLDA) state_r <= ST_XFER;
          end
          ST_XFER: begin
            if (!I_HLDA) begin
              // The outstanding read is lost: step back so it is re-read,
              // skipping the write that step already performed.
              state_r <= ST_HOLD;
              live_r  <= 1'b0;
              if (live_r && (k_r != '0)) begin
                k_r       <= k_r - (AW + 1)'(1);
                skip_wr_r <= 1'b1;
              end
            end else begin
              if ((k_r < len_r) && !mode_r) begin
                O_DMA_AS  <= src_r + k_r[AW-1:0];
                O_DMA_CES <= 1'b1;
              end
              if ((k_r != '0) && !skip_wr_r) begin
                O_DMA_AD  <= dst_r + k_r[AW-1:0] - AW'(1);
                O_DMA_DD  <= mode_r ? fill_r : I_DMA_DS;
                O_DMA_CED <= 1'b1;
              end
              skip_wr_r <= 1'b0;
              live_r    <= 1'b1;
              if (k_r == len_r) state_r <= ST_FIN;
              else k_r <= k_r + (AW + 1)'(1);
            end
          end
          ST_HOLD: begin
            if (I_HLDA) state_r <= ST_XFER;
          end
          ST_FIN: begin
            O_HRQ   <= 1'b0;
            O_BUSY  <= 1'b0;
            O_DONE  <= ch_r;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            O_HRQ   <= 1'b0;
            O_BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dkong_dma_mc.sv
// Directed self-checking bench for dkong_dma_mc with behavioural source/destination RAMs.
module tb_dkong_dma_mc;
  localparam int CH = 2;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n, clk_en, hlda, hold_force;
  logic [CH-1:0] trig, mode, done;
  logic [CH*AW-1:0] src_base, dst_base;
  logic [CH*(AW+1)-1:0] len;
  logic [DW-1:0] fill, ds, dd;
  logic hrq, ces, ced, busy;
  logic [AW-1:0] rd_addr, wr_addr;

  dkong_dma_mc #(.CH(CH), .AW(AW), .DW(DW)) dut (
    .I_CLK(clk), .I_RESET_n(rst_n), .I_CLK_EN(clk_en), .I_DMA_TRIG(trig),
    .I_SRC_BASE(src_base), .I_DST_BASE(dst_base), .I_LEN(len), .I_MODE(mode),
    .I_FILL(fill), .I_HLDA(hlda), .I_DMA_DS(ds), .O_HRQ(hrq), .O_DMA_AS(rd_addr),
    .O_DMA_CES(ces), .O_DMA_AD(wr_addr), .O_DMA_DD(dd), .O_DMA_CED(ced),
    .O_BUSY(busy), .O_DONE(done)
  );

  initial forever #5 clk = ~clk;

  // CPU-rate tick every 8 clocks; grant follows the request one tick later
  int ph = 0;
  initial begin
    clk_en = 1'b0;
    hlda   = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 8;
      clk_en = (ph == 0);
      if (clk_en) hlda = hrq && !hold_force;
    end
  end

  logic [7:0] smem [1024];
  logic [7:0] dmem [1024];
  int wcnt [1024];
  int wsnap [1024];
  int rd_cnt = 0, wr_cnt = 0, hrq_ticks = 0, hold_ticks = 0, strobe_hold = 0;
  int hrq_rise = 0, rise_at_done0 = 0;
  int done_cnt [CH];
  logic hrq_d = 1'b0;

  initial ds = 8'h00;
  always @(posedge clk) begin
    if (ces) ds <= smem[rd_addr];
  end

  always @(posedge clk) begin
    hrq_d <= hrq;
    if (hrq && !hrq_d) hrq_rise <= hrq_rise + 1;
    if (ces) rd_cnt <= rd_cnt + 1;
    if (ced) begin
      dmem[wr_addr] <= dd;
      wcnt[wr_addr] <= wcnt[wr_addr] + 1;
      wr_cnt <= wr_cnt + 1;
    end
    if (clk_en && hrq) hrq_ticks <= hrq_ticks + 1;
    if (clk_en && busy && !hlda) hold_ticks <= hold_ticks + 1;
    if ((ces || ced) && !hlda) strobe_hold <= strobe_hold + 1;
    if (done[0]) begin
      done_cnt[0] <= done_cnt[0] + 1;
      rise_at_done0 <= hrq_rise;
    end
    if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
  end

  int total = 0, bad = 0;
  int rd0, wr0, ht0, hk0, sh0, rise0, d0_0, d1_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    do step(); while (!clk_en);
  endtask

  task automatic cfg(input int ch, input logic [9:0] s, input logic [9:0] d,
                     input logic [10:0] n, input logic m);
    src_base[ch*AW +: AW] = s;
    dst_base[ch*AW +: AW] = d;
    len[ch*(AW+1) +: (AW+1)] = n;
    mode[ch] = m;
  endtask

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; ht0 = hrq_ticks; hk0 = hold_ticks;
    sh0 = strobe_hold; rise0 = hrq_rise; d0_0 = done_cnt[0]; d1_0 = done_cnt[1];
    for (int a = 0; a < 1024; a++) wsnap[a] = wcnt[a];
  endtask

  task automatic pulse(input int ch);
    trig[ch] = 1'b1;
    step();
    step();
    trig[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = done[ch];
    end
    chk(tag, seen, 1'b1);
    if (seen) chk({tag, "_tick"}, clk_en, 1'b1);
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (wr_cnt - wr0) >= n;
    end
    chk(tag, ok, 1'b1);
  endtask

  // Each destination byte in range written exactly once with the expected value
  task automatic verify(input string tag, input logic [9:0] s, input logic [9:0] d,
                        input int n, input logic fm, input logic [7:0] fv);
    int errs;
    logic [9:0] a, sa;
    logic [7:0] e;
    errs = 0;
    for (int j = 0; j < n; j++) begin
      a  = d + 10'(j);
      sa = s + 10'(j);
      e  = fm ? fv : smem[sa];
      if (dmem[a] !== e || (wcnt[a] - wsnap[a]) != 1) errs++;
    end
    chk(tag, errs, 0);
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; src_base = '0; dst_base = '0; len = '0; mode = '0;
    fill = 8'h00; hold_force = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int i = 0; i < 1024; i++) smem[i] = 8'(i * 37 + (i >> 3));
    repeat (3) step();
    chk("rst_ctl", {hrq, busy, ces, ced, done}, 0);
    chk("rst_addr", {rd_addr, wr_addr}, 0);
    chk("rst_dd", dd, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Sprite copy, ch0 0x100 -> 0x000, 0x180 bytes
    cfg(0, 10'h100, 10'h000, 11'h180, 1'b0);
    snap();
    tick();
    pulse(0);
    chk("lat_pre", hrq, 1'b0);
    tick();
    chk("lat_hrq", hrq, 1'b1);
    chk("busy_on", busy, 1'b1);
    wait_done(0, 5000, "sc_done");
    step();
    chk("sc_reads", rd_cnt - rd0, 32'h180);
    chk("sc_writes", wr_cnt - wr0, 32'h180);
    chk("sc_hrq_ticks", hrq_ticks - ht0, 32'h183);
    chk("sc_done_cnt", done_cnt[0] - d0_0, 1);
    chk("sc_hrq_low", {hrq, busy}, 0);
    verify("sc_data", 10'h100, 10'h000, 32'h180, 1'b0, 8'h00);

    // Fill with wrap, ch1 at 0x3F0
    fill = 8'h00;
    cfg(1, 10'h000, 10'h3F0, 11'h020, 1'b1);
    snap();
    pulse(1);
    wait_done(1, 1000, "fill_done");
    step();
    chk("fill_no_ces", rd_cnt - rd0, 0);
    chk("fill_writes", wr_cnt - wr0, 32'h20);
    verify("fill_data", 10'h000, 10'h3F0, 32, 1'b1, 8'h00);

    // Priority: both triggered together, extra ch1 edge during ch0
    cfg(0, 10'h300, 10'h040, 11'd4, 1'b0);
    cfg(1, 10'h000, 10'h050, 11'd3, 1'b1);
    fill = 8'h5A;
    snap();
    trig = 2'b11;
    step();
    step();
    trig = 2'b00;
    wait_wr(1, 500, "pri_wait");
    pulse(1);
    wait_done(1, 2000, "pri_done1");
    repeat (80) step();
    chk("pri_done0_cnt", done_cnt[0] - d0_0, 1);
    chk("pri_done1_cnt", done_cnt[1] - d1_0, 1);
    chk("pri_order", rise_at_done0 - rise0, 1);
    chk("pri_rises", hrq_rise - rise0, 2);
    verify("pri_data0", 10'h300, 10'h040, 4, 1'b0, 8'h00);
    verify("pri_data1", 10'h000, 10'h050, 3, 1'b1, 8'h5A);

    // Grant withdrawn for 5 ticks near k = 10 of a 32-byte copy
    cfg(0, 10'h200, 10'h080, 11'd32, 1'b0);
    snap();
    pulse(0);
    wait_wr(10, 2000, "hold_wait");
    hold_force = 1'b1;
    repeat (5) tick();
    hold_force = 1'b0;
    wait_done(0, 2000, "hold_done");
    step();
    chk("hold_ticks", hold_ticks - hk0, 5);
    chk("hold_strobes", strobe_hold - sh0, 0);
    chk("hold_writes", wr_cnt - wr0, 32);
    verify("hold_data", 10'h200, 10'h080, 32, 1'b0, 8'h00);

    // Zero length: done pulse without a bus request
    cfg(1, 10'h000, 10'h000, 11'd0, 1'b0);
    snap();
    pulse(1);
    wait_done(1, 200, "len0_done");
    step();
    chk("len0_no_hrq", hrq_rise - rise0, 0);
    chk("len0_done_cnt", done_cnt[1] - d1_0, 1);
    chk("len0_no_wr", wr_cnt - wr0, 0);

    // Asynchronous reset in the middle of a copy
    cfg(0, 10'h000, 10'h100, 11'd100, 1'b0);
    snap();
    pulse(0);
    wait_wr(50, 3000, "rst_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {hrq, busy, ces, ced, done}, 0);
    chk("rst_async_addr", {rd_addr, wr_addr}, 0);
    chk("rst_async_dd", dd, 0);
    repeat (3) step();
    rst_n = 1'b1;
    snap();
    repeat (200) step();
    chk("rst_no_rerun", hrq_rise - rise0, 0);
    chk("rst_no_reads", rd_cnt - rd0, 0);

    // A fresh edge after reset runs normally
    cfg(0, 10'h010, 10'h200, 11'd2, 1'b0);
    snap();
    pulse(0);
    wait_done(0, 500, "post_rst_done");
    step();
    verify("post_rst_data", 10'h010, 10'h200, 2, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
